// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel debouncer.
package debounce_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        CHECK_HIGH = 2'b01,
        HIGH_STATE = 2'b10,
        CHECK_LOW  = 2'b11
    } state_e;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, four-state FSM with integrated counter, edge flags.
// Edge pulses are built only when MULTI_DEBOUNCER_EDGE_EN is defined.
import debounce_pkg::*;

module debounce_channel #(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [CNT_W-1:0] debounce_limit,
    output logic             dout,
    output logic             rise_pulse,
    output logic             fall_pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d, lim_m1;
    state_e                 state_q, state_d;
    logic                   s, done;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A zero limit acts as one; the counter saturates at lim-1 so it cannot wrap.
    always_comb begin
        lim_m1  = (debounce_limit == '0) ? '0 : debounce_limit - CNT_W'(1);
        done    = (cnt_q >= lim_m1);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (s) begin
                state_d = CHECK_HIGH;
                cnt_d   = '0;
            end
            CHECK_HIGH: begin
                if (!s)        state_d = IDLE;
                else if (done) state_d = HIGH_STATE;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            HIGH_STATE: if (!s) begin
                state_d = CHECK_LOW;
                cnt_d   = '0;
            end
            CHECK_LOW: begin
                if (s)         state_d = HIGH_STATE;
                else if (done) state_d = IDLE;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // HIGH_STATE and CHECK_LOW both carry the MSB set.
    assign dout = state_q[1];

`ifdef MULTI_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == CHECK_HIGH) && (state_d == HIGH_STATE);
            fall_q <= (state_q == CHECK_LOW)  && (state_d == IDLE);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif
endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer top: CHANNELS independent channels sharing one debounce interval.
// Optional edge pulses controlled by MULTI_DEBOUNCER_EDGE_EN.
import debounce_pkg::*;

module multi_debouncer #(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    input  logic [CNT_W-1:0]    debounce_limit,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .din           (din[i]),
            .debounce_limit(debounce_limit),
            .dout          (dout[i]),
            .rise_pulse    (rise_pulse[i]),
            .fall_pulse    (fall_pulse[i])
        );
    end
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (default parameters).
module tb_multi_debouncer;
    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic [15:0] debounce_limit;
    logic [3:0]  dout, rise_pulse, fall_pulse;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MULTI_DEBOUNCER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    multi_debouncer dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .debounce_limit(debounce_limit),
        .dout          (dout),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles; dout switches from d0 to d1 at cycle 'at', pulses only in that cycle.
    task automatic watch(input string tag, input int n, input int at,
                         input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] rv, input logic [3:0] fv);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, "_dout"}, 32'(dout), 32'((i >= at) ? d1 : d0));
            chk({tag, "_rise"}, 32'(rise_pulse), 32'((EDGE && i == at) ? rv : 4'h0));
            chk({tag, "_fall"}, 32'(fall_pulse), 32'((EDGE && i == at) ? fv : 4'h0));
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 4'hF;
        debounce_limit = 16'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_dout", 32'(dout), 32'h0);
            chk("rst_rise", 32'(rise_pulse), 32'h0);
            chk("rst_fall", 32'(fall_pulse), 32'h0);
        end
        rst = 1'b0;
        watch("rst_release", 8, 7, 4'h0, 4'hF, 4'hF, 4'h0);
        din = 4'h0;
        watch("all_fall", 8, 7, 4'hF, 4'h0, 4'h0, 4'hF);

        din = 4'b0001;
        watch("step_rise", 8, 7, 4'h0, 4'h1, 4'h1, 4'h0);
        din = 4'b0000;
        watch("step_fall", 8, 7, 4'h1, 4'h0, 4'h0, 4'h1);

        din = 4'b0010;
        watch("mid_pre", 5, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        chk("mid_rst_dout", 32'(dout), 32'h0);
        chk("mid_rst_rise", 32'(rise_pulse), 32'h0);
        rst = 1'b0;
        watch("mid_restart", 8, 7, 4'h0, 4'h2, 4'h2, 4'h0);
        din = 4'b0000;
        watch("mid_fall", 8, 7, 4'h2, 4'h0, 4'h0, 4'h2);

        din = 4'b0010;
        watch("bounce_a", 2, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        din = 4'b0000;
        watch("bounce_b", 1, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        din = 4'b0010;
        watch("bounce_c", 8, 7, 4'h0, 4'h2, 4'h2, 4'h0);
        din = 4'b0000;
        watch("bounce_fall", 8, 7, 4'h2, 4'h0, 4'h0, 4'h2);

        din = 4'b0100;
        watch("abort_rise", 7, 7, 4'h0, 4'h4, 4'h4, 4'h0);
        din = 4'b0000;
        watch("abort_low", 3, 99, 4'h4, 4'h4, 4'h0, 4'h0);
        din = 4'b0100;
        watch("abort_back", 9, 99, 4'h4, 4'h4, 4'h0, 4'h0);
        din = 4'b0000;
        watch("abort_fall", 8, 7, 4'h4, 4'h0, 4'h0, 4'h4);

        debounce_limit = 16'd0;
        din = 4'b1000;
        watch("lim0_rise", 5, 4, 4'h0, 4'h8, 4'h8, 4'h0);
        din = 4'b0000;
        watch("lim0_fall", 5, 4, 4'h8, 4'h0, 4'h0, 4'h8);

        debounce_limit = 16'hFFFF;
        din = 4'b0001;
        watch("limmax_hold", 20, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        din = 4'b0000;
        watch("limmax_drop", 4, 99, 4'h0, 4'h0, 4'h0, 4'h0);

        debounce_limit = 16'd100;
        din = 4'b0001;
        watch("lower_pre", 10, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        debounce_limit = 16'd2;
        watch("lower_done", 3, 1, 4'h0, 4'h1, 4'h1, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
